lcd_text_sequencer: RTL and testbench
=====================================

// Module: lcd_text_sequencer
// PURPOSE
//  Upstream feeder for the LCD 1602A controller. Holds a 2-line text frame
//  buffer written by the host. On each refresh request it drives the controller's
//  op/data/enable inputs through one op per lcd_rdy handshake:
//  INIT (first refresh after reset only), CLEAR, line 1 chars, DDRAM-address
//  command, line 2 chars.
// PARAMETERS
//  COLS        16   characters per line (1..40); buffer depth = 2*COLS
//  AW          5    buffer address width, >= clog2(2*COLS)
//  OPW         6    op_out width, equal to controller NCOMMANDS+1
//  ACK_TIMEOUT 8    cycles allowed for lcd_rdy to fall after an issue
// PORTS
//  clk         in   1    system clock (20 MHz)
//  rst         in   1    asynchronous reset, active-low
//  wr_en       in   1    host buffer write strobe
//  wr_addr     in   AW   buffer address; 0..COLS-1 = line 1, COLS..2*COLS-1 = line 2
//  wr_data     in   8    character code
//  refresh     in   1    one-cycle request to redraw the whole screen
//  busy        out  1    high from refresh acceptance to done
//  done        out  1    one-cycle pulse when the last char is acknowledged
//  err         out  1    sticky: ack timeout seen; cleared by reset only
//  op_out      out  OPW  one-hot op to controller op_in
//  data_out    out  8    character/command byte to controller data_in
//  lcd_enable  out  1    one-cycle issue strobe to controller enable
//  lcd_rdy     in   1    controller ready (ctrl_rdy & driver_rdy)
// BEHAVIOUR
//  - Reset values: busy=0, done=0, err=0, op_out=0, data_out=0, lcd_enable=0,
//    init_done flag=0, FSM=IDLE. Buffer contents are not reset. After reset the
//    buffer must be written or the screen shows undefined chars.
//  - Op encoding, one-hot: bit0 INIT, bit1 CLEAR, bit2 WRITE (data_out=char),
//    bit3 CMD (data_out=raw command byte). Bits above 3 are always 0.
//  - FSM: IDLE -> ISSUE -> WAIT_ACK -> WAIT_DONE -> ISSUE | FINISH -> IDLE.
//  - IDLE: refresh=1 and lcd_rdy=1 accept the request; busy rises next cycle.
//    refresh while busy, or while lcd_rdy=0, is dropped (no queueing).
//  - Step sequence: INIT if init_done=0 (then set init_done), CLEAR,
//    WRITE buf[0..COLS-1], CMD 8'hC0, WRITE buf[COLS..2*COLS-1].
//  - ISSUE: lcd_enable=1 for exactly one cycle. op_out and data_out are valid in
//    that cycle and are held stable until the FSM leaves WAIT_DONE.
//  - WAIT_ACK: wait for lcd_rdy=0. If it is not seen within ACK_TIMEOUT cycles,
//    set err and go to WAIT_DONE; the step is treated as accepted.
//  - WAIT_DONE: wait for lcd_rdy=1. Then advance the step index and go to ISSUE;
//    after the last step go to FINISH.
//  - FINISH: done=1 for one cycle, busy=0 in the same cycle, op_out=0.
//  - Issue rate: at most one op per 3 cycles. No inter-op delays are generated
//    here; the controller owns all LCD timing.
//  - Char fetch: the char is read from the buffer in the ISSUE cycle. A host
//    write to the same address in that cycle is bypassed (write-first). Writes
//    to already-sent addresses during busy appear on the next refresh.
//  - Out-of-range wr_addr (>= 2*COLS): the write is ignored.
//  - Step index counts 0..2*COLS+2. All comparisons are unsigned; no wrap.
//  - Reset mid-operation: abort immediately and return all outputs to their
//    reset values. init_done is cleared, so the next refresh re-issues INIT.
// STRUCTURE
//  - Package lcd_pkg: LCD_OP_INIT/CLEAR/WRITE/CMD one-hot localparams,
//    LCD_DDRAM_LINE1=8'h80, LCD_DDRAM_LINE2=8'hC0, FSM state encoding.
//  - Sub-module lcd_frame_buffer: 2*COLS x 8 register array with one sync write
//    port, one async read port and write-first bypass.
//  - The top level contains the FSM, step counter and timeout counter.
// TESTING
//  - Reset, write "HELLO" at addr 0..4, refresh; controller model acks in 5 cycles
//    -> ops INIT, CLEAR, 16xWRITE ('H','E','L','L','O', then buffer contents),
//    CMD C0, 16xWRITE; done pulses once and busy falls in the done cycle.
//  - Second refresh without reset -> no INIT; first op is CLEAR; 34 enables total
//    for COLS=16.
//  - Model never drops lcd_rdy -> err=1 after 8 cycles on the first op; the
//    sequence still completes and done pulses.
//  - Refresh pulsed while busy -> ignored; exactly one done and the enable count
//    is unchanged.
//  - Host writes 'Z' to addr 17 in the ISSUE cycle of that char -> data_out=8'h5A.
//  - rst low during line 2 -> all outputs 0 asynchronously; next refresh starts
//    with INIT.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared op encodings, LCD command bytes and sequencer state encoding
// for the LCD 1602A text feeder.
package lcd_pkg;

  localparam logic [3:0] LCD_OP_INIT  = 4'b0001;
  localparam logic [3:0] LCD_OP_CLEAR = 4'b0010;
  localparam logic [3:0] LCD_OP_WRITE = 4'b0100;
  localparam logic [3:0] LCD_OP_CMD   = 4'b1000;

  localparam logic [7:0] LCD_DDRAM_LINE1 = 8'h80;
  localparam logic [7:0] LCD_DDRAM_LINE2 = 8'hC0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_FINISH
  } seq_state_t;

endpackage

// File: rtl/lcd_frame_buffer.sv
// Two-line character frame buffer: one synchronous write port and one
// asynchronous read port that returns same-cycle write data (write-first).
module lcd_frame_buffer #(
  parameter int COLS = 16,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  localparam int DEPTH = 2 * COLS;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_mem;

  // Per-entry address decode: out-of-range addresses match no entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (wr_en && (wr_addr == AW'(gi))) begin
        mem_q[gi] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_mem = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == AW'(i)) rd_mem = mem_q[i];
    end
  end

  assign rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : rd_mem;

endmodule

// File: rtl/lcd_text_sequencer.sv
// Redraws the whole 2-line frame on refresh, issuing one controller op per
// lcd_rdy handshake: INIT (once after reset), CLEAR, line 1, DDRAM cmd, line 2.
module lcd_text_sequencer
  import lcd_pkg::*;
#(
  parameter int COLS        = 16,
  parameter int AW          = 5,
  parameter int OPW         = 6,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [7:0]     wr_data,
  input  logic           refresh,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [OPW-1:0] op_out,
  output logic [7:0]     data_out,
  output logic           lcd_enable,
  input  logic           lcd_rdy
);

  localparam int LAST = 2 * COLS + 2;
  localparam int SW   = $clog2(LAST + 1);
  localparam int TW   = $clog2(ACK_TIMEOUT + 1);

  seq_state_t    state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          init_done_q, init_done_d;
  logic [3:0]    op_hold_q, op_hold_d;
  logic [7:0]    data_hold_q, data_hold_d;

  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [3:0]    cur_op;
  logic [7:0]    cur_data;
  logic [3:0]    op4;

  lcd_frame_buffer #(.COLS(COLS), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Step map: 0 INIT, 1 CLEAR, 2..COLS+1 line 1, COLS+2 CMD, then line 2.
  always_comb begin
    rd_addr  = '0;
    cur_op   = LCD_OP_WRITE;
    cur_data = rd_data;
    if (step_q == SW'(0)) begin
      cur_op   = LCD_OP_INIT;
      cur_data = 8'h00;
    end else if (step_q == SW'(1)) begin
      cur_op   = LCD_OP_CLEAR;
      cur_data = 8'h00;
    end else if (step_q <= SW'(COLS + 1)) begin
      rd_addr = AW'(step_q - SW'(2));
    end else if (step_q == SW'(COLS + 2)) begin
      cur_op   = LCD_OP_CMD;
      cur_data = LCD_DDRAM_LINE2;
    end else begin
      rd_addr = AW'(step_q - SW'(3));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
      op_hold_q   <= '0;
      data_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      init_done_q <= init_done_d;
      op_hold_q   <= op_hold_d;
      data_hold_q <= data_hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    init_done_d = init_done_q;
    op_hold_d   = op_hold_q;
    data_hold_d = data_hold_q;
    case (state_q)
      ST_IDLE: begin
        if (refresh && lcd_rdy) begin
          state_d = ST_ISSUE;
          step_d  = init_done_q ? SW'(1) : SW'(0);
        end
      end
      ST_ISSUE: begin
        op_hold_d   = cur_op;
        data_hold_d = cur_data;
        tmo_d       = '0;
        if (step_q == SW'(0)) init_done_d = 1'b1;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // A missing ack is flagged but the step still counts as accepted.
        if (!lcd_rdy) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_WAIT_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (lcd_rdy) begin
          if (step_q == SW'(LAST)) begin
            state_d = ST_FINISH;
          end else begin
            step_d  = step_q + SW'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op4        = 4'b0000;
    data_out   = 8'h00;
    lcd_enable = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        op4        = cur_op;
        data_out   = cur_data;
        lcd_enable = 1'b1;
        busy       = 1'b1;
      end
      ST_WAIT_ACK, ST_WAIT_DONE: begin
        op4      = op_hold_q;
        data_out = data_hold_q;
        busy     = 1'b1;
      end
      ST_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  assign op_out = OPW'(op4);
  assign err    = err_q;

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Scoreboard bench for lcd_text_sequencer: a controller model acks each op,
// expected ops are queued per refresh and popped on every lcd_enable.
module tb_lcd_text_sequencer;
  import lcd_pkg::*;

  localparam int COLS = 16;
  localparam int AW   = 6;
  localparam int OPW  = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [7:0]     wr_data;
  logic           refresh;
  logic           busy, done, err, lcd_enable;
  logic [OPW-1:0] op_out;
  logic [7:0]     data_out;
  logic           lcd_rdy = 1'b1;

  lcd_text_sequencer #(.COLS(COLS), .AW(AW), .OPW(OPW), .ACK_TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .refresh    (refresh),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .op_out     (op_out),
    .data_out   (data_out),
    .lcd_enable (lcd_enable),
    .lcd_rdy    (lcd_rdy)
  );

  always #25 clk = ~clk;

  typedef struct {
    logic [OPW-1:0] op;
    logic [7:0]     data;
    bit             chk_data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] exp_buf [2*COLS];
  int         n_cmp = 0;
  int         n_mis = 0;
  int         en_cnt = 0;
  int         done_cnt = 0;
  int         rdy_cnt = 0;
  bit         no_drop = 1'b0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller model: rdy falls after an enable and returns 5 cycles later.
  always @(negedge clk) begin
    if (!rst) begin
      lcd_rdy = 1'b1;
      rdy_cnt = 0;
    end else if (lcd_enable && !no_drop) begin
      lcd_rdy = 1'b0;
      rdy_cnt = 5;
    end else if (rdy_cnt > 0) begin
      rdy_cnt--;
      if (rdy_cnt == 0) lcd_rdy = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst && lcd_enable) begin
      en_cnt++;
      if (exp_q.size() == 0) begin
        chk_val("unexpected_op", 32'(exp_q.size()), 1);
      end else begin
        mon_e = exp_q.pop_front();
        $display("op #%0d: op=%b data=%h (exp op=%b data=%h)", en_cnt, op_out, data_out,
                 mon_e.op, mon_e.data);
        chk_val("op", op_out, mon_e.op);
        if (mon_e.chk_data) chk_val("data", data_out, mon_e.data);
      end
    end
    if (rst && done) begin
      done_cnt++;
      chk_val("busy_at_done", busy, 0);
      chk_val("op_at_done", op_out, 0);
    end
  end

  task automatic bus_write(input logic [AW-1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (a < AW'(2*COLS)) exp_buf[a[4:0]] = d;
  endtask

  task automatic push_seq(input bit with_init);
    if (with_init) exp_q.push_back('{OPW'(LCD_OP_INIT), 8'h00, 1'b0});
    exp_q.push_back('{OPW'(LCD_OP_CLEAR), 8'h00, 1'b0});
    for (int i = 0; i < COLS; i++) exp_q.push_back('{OPW'(LCD_OP_WRITE), exp_buf[i], 1'b1});
    exp_q.push_back('{OPW'(LCD_OP_CMD), 8'hC0, 1'b1});
    for (int i = 0; i < COLS; i++) exp_q.push_back('{OPW'(LCD_OP_WRITE), exp_buf[COLS+i], 1'b1});
  endtask

  task automatic run_refresh(input bit with_init, input int extra_at, input int z_idx,
                             input bit chk_tmo, input int budget);
    int base_en, base_done, cyc;
    bit fin;
    base_en   = en_cnt;
    base_done = done_cnt;
    push_seq(with_init);
    @(posedge clk); #1; refresh = 1'b1;
    @(posedge clk); #1; refresh = 1'b0;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < budget) begin
      refresh = (cyc == extra_at);
      wr_en   = 1'b0;
      if (chk_tmo && cyc == 7)  chk_val("err_before_tmo", err, 0);
      if (chk_tmo && cyc == 11) chk_val("err_after_tmo", err, 1);
      if (z_idx >= 0 && lcd_enable && (en_cnt - base_en) == z_idx) begin
        wr_en = 1'b1; wr_addr = AW'(17); wr_data = 8'h5A;
        @(negedge clk);
        chk_val("z_bypass", data_out, 8'h5A);
      end
      @(posedge clk); #1;
      cyc++;
      if (done_cnt != base_done) fin = 1'b1;
    end
    refresh = 1'b0;
    wr_en   = 1'b0;
    chk_val("done_seen", fin, 1);
    chk_val("enables", en_cnt - base_en, with_init ? 2*COLS+3 : 2*COLS+2);
    repeat (3) @(posedge clk);
    #1;
    chk_val("done_count", done_cnt - base_done, 1);
    chk_val("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string pfx);
    chk_val({pfx, "_busy"}, busy, 0);
    chk_val({pfx, "_done"}, done, 0);
    chk_val({pfx, "_err"}, err, 0);
    chk_val({pfx, "_op"}, op_out, 0);
    chk_val({pfx, "_data"}, data_out, 0);
    chk_val({pfx, "_enable"}, lcd_enable, 0);
  endtask

  initial begin
    string hello;
    int    base_en, cyc;
    hello   = "HELLO";
    rst     = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = 8'h00;
    refresh = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;

    for (int i = 0; i < 2*COLS; i++) bus_write(AW'(i), 8'(8'h61 + i));
    for (int i = 0; i < 5; i++) bus_write(AW'(i), hello[i]);

    run_refresh(1'b1, -1, -1, 1'b0, 2000);
    run_refresh(1'b0, 20, -1, 1'b0, 2000);

    exp_buf[17] = 8'h5A;
    run_refresh(1'b0, -1, 19, 1'b0, 2000);

    bus_write(AW'(33), 8'h51);
    no_drop = 1'b1;
    run_refresh(1'b0, -1, -1, 1'b1, 1000);
    chk_val("err_sticky", err, 1);
    no_drop = 1'b0;

    // Abort partway through line 2 with an asynchronous reset.
    base_en = en_cnt;
    push_seq(1'b0);
    @(posedge clk); #1; refresh = 1'b1;
    @(posedge clk); #1; refresh = 1'b0;
    cyc = 0;
    while ((en_cnt - base_en) < 25 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk_val("abort_reached", ((en_cnt - base_en) >= 25), 1);
    #10;
    rst = 1'b0;
    #1;
    check_idle_outputs("abort");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    run_refresh(1'b1, -1, -1, 1'b0, 2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
